// File: rtl/led_sequence_player.sv
// Timed RGB colour playback: colour codes queue in a small FIFO and each one is
// shown for ON_CYCLES clocks, followed by a dark gap of OFF_CYCLES clocks.
module led_sequence_player #(
  parameter int ON_CYCLES  = 50_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in_color,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic       led_red,
  output logic       led_green,
  output logic       led_blue,
  output logic       busy,
  output logic       done
);

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int PTR_W      = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       color, color_next;
  logic [2:0]       led_next;
  logic             done_next;

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, empty, full;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign busy     = (state != IDLE) || !empty;

  // A pop and a push in the same cycle leave the count untouched.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_color;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    color_next = color;
    pop        = 1'b0;
    done_next  = 1'b0;
    led_next   = 3'b000;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          color_next = mem[rd_ptr];
          cnt_next   = '0;
          state_next = ON;
        end
      end
      ON: begin
        if (cnt == ON_LAST) begin
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == OFF_LAST) begin
          cnt_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            color_next = mem[rd_ptr];
            state_next = ON;
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    // LEDs are registered from the next state so they track the ON state exactly.
    if (state_next == ON) begin
      case (color_next)
        2'b00:   led_next = 3'b100;
        2'b01:   led_next = 3'b010;
        2'b10:   led_next = 3'b001;
        default: led_next = 3'b110;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      cnt       <= '0;
      color     <= 2'b00;
      led_red   <= 1'b0;
      led_green <= 1'b0;
      led_blue  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      color     <= color_next;
      led_red   <= led_next[2];
      led_green <= led_next[1];
      led_blue  <= led_next[0];
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_led_sequence_player.sv
// Bench for led_sequence_player: a directed vector table, hand-written corner
// sequences and random traffic, all checked against a colour-timeline model.
module tb_led_sequence_player;

  localparam int ON_C  = 4;
  localparam int OFF_C = 2;
  localparam int DEP   = 4;

  logic       clk;
  logic       rst;
  logic [1:0] in_color;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic       led_red, led_green, led_blue;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  led_sequence_player #(
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .DEPTH     (DEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_color (in_color),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .led_red  (led_red),
    .led_green(led_green),
    .led_blue (led_blue),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending colours, plus the LED timeline of the colour being played.
  logic [1:0] mq[$];
  logic [2:0] tl[$];
  bit         m_active;
  logic [2:0] m_led;
  bit         m_done;

  function automatic logic [2:0] colourLeds(input logic [1:0] c);
    case (c)
      2'b00:   return 3'b100;
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  task automatic modelStep(input logic r, input logic f, input logic v, input logic [1:0] c);
    bit         ready_pre;
    logic [1:0] head;
    ready_pre = (mq.size() < DEP);
    m_done    = 0;
    if (r || f) begin
      mq.delete();
      tl.delete();
      m_active = 0;
      m_led    = 3'b000;
    end else begin
      if (m_active && tl.size() > 0) begin
        m_led = tl.pop_front();
      end else begin
        if (m_active && mq.size() == 0) m_done = 1;
        if (mq.size() > 0) begin
          head = mq.pop_front();
          for (int i = 0; i < ON_C; i++)  tl.push_back(colourLeds(head));
          for (int i = 0; i < OFF_C; i++) tl.push_back(3'b000);
          m_led    = tl.pop_front();
          m_active = 1;
        end else begin
          m_active = 0;
          m_led    = 3'b000;
        end
      end
      if (v && ready_pre) mq.push_back(c);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic [1:0] c);
    rst      = r;
    flush    = f;
    in_valid = v;
    in_color = c;
    @(posedge clk);
    modelStep(r, f, v, c);
    #1;
  endtask

  task automatic checkOne(input string name, input string what, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s %s: actual=%b required=%b at %0t", name, what, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [2:0] e_led, input logic e_busy,
                             input logic e_ready, input logic e_done);
    checkOne(name, "leds",  {led_red, led_green, led_blue}, e_led);
    checkOne(name, "busy",  {2'b00, busy},     {2'b00, e_busy});
    checkOne(name, "ready", {2'b00, in_ready}, {2'b00, e_ready});
    checkOne(name, "done",  {2'b00, done},     {2'b00, e_done});
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_led, (m_active || mq.size() > 0), (mq.size() < DEP), m_done);
  endtask

  task automatic stepModel(input string name, input logic r, input logic f, input logic v, input logic [1:0] c);
    applyStimulus(r, f, v, c);
    checkModel(name);
  endtask

  // Holds in_valid until the code is accepted, checking every cycle.
  task automatic pushCode(input string name, input logic [1:0] c);
    bit accepted;
    accepted = 0;
    for (int k = 0; k < 100 && !accepted; k++) begin
      accepted = (mq.size() < DEP);
      stepModel(name, 1'b0, 1'b0, 1'b1, c);
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s push timeout: actual=not accepted required=accepted", name);
    end
  endtask

  task automatic waitIdle(input string name);
    int k;
    k = 0;
    while ((m_active || mq.size() > 0 || m_done) && k < 200) begin
      stepModel(name, 1'b0, 1'b0, 1'b0, 2'b00);
      k++;
    end
    stepModel(name, 1'b0, 1'b0, 1'b0, 2'b00);
    if (k >= 200) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s idle timeout: actual=busy required=idle", name);
    end
  endtask

  typedef struct {
    logic       r, f, v;
    logic [1:0] c;
    logic [2:0] led;
    logic       busy, ready, done;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;

    // Single green push: lit 4, dark 2, done for one cycle.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0};

    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_color = 2'b00;
    m_active = 0;
    m_led    = 3'b000;
    m_done   = 0;
    @(posedge clk);
    #1;

    $display("[TB] table: single green");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].c);
      checkOutput($sformatf("table[%0d]", i), vecs[i].led, vecs[i].busy, vecs[i].ready, vecs[i].done);
    end

    $display("[TB] back-to-back red, blue, yellow");
    pushCode("b2b", 2'b00);
    pushCode("b2b", 2'b10);
    pushCode("b2b", 2'b11);
    waitIdle("b2b");

    $display("[TB] six codes held on in_valid");
    pushCode("hold6", 2'b11);
    pushCode("hold6", 2'b00);
    pushCode("hold6", 2'b01);
    pushCode("hold6", 2'b10);
    pushCode("hold6", 2'b10);
    pushCode("hold6", 2'b01);
    waitIdle("hold6");

    $display("[TB] full FIFO refilled as the head pops");
    for (int i = 0; i < 5; i++) pushCode("full", 2'(i));
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full ready: actual=%b required=0", in_ready);
    end
    pushCode("full", 2'b11);
    waitIdle("full");

    $display("[TB] reset on second blue ON cycle");
    pushCode("rst_mid", 2'b01);
    pushCode("rst_mid", 2'b10);
    pushCode("rst_mid", 2'b00);
    pushCode("rst_mid", 2'b01);
    pushCode("rst_mid", 2'b11);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (m_led == 3'b001 && tl.size() == ON_C - 2 + OFF_C) found = 1;
      else stepModel("rst_mid", 1'b0, 1'b0, 1'b0, 2'b00);
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL rst_mid reach: actual=not reached required=blue ON cycle 2");
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b11);
    checkOutput("rst_mid after", 3'b000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) stepModel("rst_mid quiet", 1'b0, 1'b0, 1'b0, 2'b00);

    $display("[TB] flush during gap with push");
    pushCode("flush_gap", 2'b11);
    pushCode("flush_gap", 2'b00);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (m_active && m_led == 3'b000) found = 1;
      else stepModel("flush_gap", 1'b0, 1'b0, 1'b0, 2'b00);
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL flush_gap reach: actual=not reached required=gap");
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10);
    checkOutput("flush_gap after", 3'b000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) stepModel("flush_gap quiet", 1'b0, 1'b0, 1'b0, 2'b00);

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++) begin
      stepModel("random",
                ($urandom_range(0, 149) == 0),
                ($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)));
    end
    waitIdle("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
